// File: rtl/riscv_inst_encoder_pkg.sv
// Shared RV32I encoding definitions: request opcodes, field constants and
// immediate ranges used by the encoder (and kept consistent with the decoder).
package riscv_defs;

   typedef enum logic [3:0] {
      ENC_ADD  = 4'd0,
      ENC_SUB  = 4'd1,
      ENC_SLT  = 4'd2,
      ENC_OR   = 4'd3,
      ENC_AND  = 4'd4,
      ENC_ADDI = 4'd5,
      ENC_LW   = 4'd6,
      ENC_SW   = 4'd7,
      ENC_JAL  = 4'd8,
      ENC_BEQ  = 4'd9
   } enc_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_ADDI    = 3'b000;
   localparam logic [2:0] F3_LW_SW   = 3'b010;
   localparam logic [2:0] F3_BEQ     = 3'b000;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_SUB  = 7'h20;

   localparam int IMM_I_MIN = -2048;
   localparam int IMM_I_MAX = 2047;
   localparam int IMM_B_MIN = -4096;
   localparam int IMM_B_MAX = 4094;
   localparam int IMM_J_MIN = -1048576;
   localparam int IMM_J_MAX = 1048574;

   // Signed inclusive range test on a 32-bit immediate.
   function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
      return ($signed(imm) >= lo) && ($signed(imm) <= hi);
   endfunction

endpackage

// File: rtl/riscv_inst_encoder_pack.sv
// Combinational field packer: request op + fields -> RV32I word, with an
// illegal flag for undefined ops and out-of-range / misaligned immediates.
module riscv_inst_pack
   import riscv_defs::*;
(
   input  logic [3:0]  op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        illegal
);

   // Select the instruction format for the op and check its immediate.
   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (op)
         ENC_ADD: word = {F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OPC_OP};
         ENC_SUB: word = {F7_SUB,  rs2, rs1, F3_ADD_SUB, rd, OPC_OP};
         ENC_SLT: word = {F7_BASE, rs2, rs1, F3_SLT,     rd, OPC_OP};
         ENC_OR:  word = {F7_BASE, rs2, rs1, F3_OR,      rd, OPC_OP};
         ENC_AND: word = {F7_BASE, rs2, rs1, F3_AND,     rd, OPC_OP};
         ENC_ADDI: begin
            word    = {imm[11:0], rs1, F3_ADDI, rd, OPC_OP_IMM};
            illegal = !imm_in_range(imm, IMM_I_MIN, IMM_I_MAX);
         end
         ENC_LW: begin
            word    = {imm[11:0], rs1, F3_LW_SW, rd, OPC_LOAD};
            illegal = !imm_in_range(imm, IMM_I_MIN, IMM_I_MAX);
         end
         ENC_SW: begin
            word    = {imm[11:5], rs2, rs1, F3_LW_SW, imm[4:0], OPC_STORE};
            illegal = !imm_in_range(imm, IMM_I_MIN, IMM_I_MAX);
         end
         ENC_BEQ: begin
            word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
            illegal = !imm_in_range(imm, IMM_B_MIN, IMM_B_MAX) || imm[0];
         end
         ENC_JAL: begin
            word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            illegal = !imm_in_range(imm, IMM_J_MIN, IMM_J_MAX) || imm[0];
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/riscv_inst_encoder.sv
// Program loader: accepts field-level instruction requests, encodes them and
// streams the words into instruction memory through a single output register.
module riscv_inst_encoder
   import riscv_defs::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int unsigned DEPTH     = 1024
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_op,
   input  logic [4:0]               in_rd,
   input  logic [4:0]               in_rs1,
   input  logic [4:0]               in_rs2,
   input  logic [31:0]              in_imm,
   input  logic                     in_last,
   output logic                     imem_we,
   input  logic                     imem_ready,
   output logic [31:0]              imem_addr,
   output logic [31:0]              imem_wdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err,
   output logic                     done
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;

   state_e      state, state_nxt;
   logic        accept, wr_hs, full, drop;
   logic [31:0] pack_word;
   logic        pack_illegal;

   riscv_inst_pack u_pack (
      .op      (in_op),
      .rd      (in_rd),
      .rs1     (in_rs1),
      .rs2     (in_rs2),
      .imm     (in_imm),
      .word    (pack_word),
      .illegal (pack_illegal)
   );

   // Handshakes and drop decision; full counts the word still in the output register.
   always_comb begin
      accept = in_valid && in_ready;
      wr_hs  = imem_we && imem_ready;
      full   = (32'(count) + 32'(imem_we)) >= DEPTH;
      drop   = pack_illegal || full;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic plus the state-derived outputs in_ready and done.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nxt = S_LOAD;
         S_LOAD: begin
            in_ready = !imem_we || imem_ready;
            if (in_valid && in_ready && in_last) state_nxt = S_DRAIN;
         end
         S_DRAIN: if (!imem_we) state_nxt = S_DONE;
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output register, write address, word count and sticky error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imem_we    <= 1'b0;
         imem_addr  <= BASE_ADDR;
         imem_wdata <= '0;
         count      <= '0;
         err        <= 1'b0;
      end else if (state == S_IDLE && start) begin
         imem_addr <= BASE_ADDR;
         count     <= '0;
         err       <= 1'b0;
      end else begin
         if (wr_hs) begin
            imem_addr <= imem_addr + 32'd4;
            if (32'(count) < DEPTH) count <= count + CW'(1);
         end
         if (accept && !drop) begin
            imem_we    <= 1'b1;
            imem_wdata <= pack_word;
         end else if (wr_hs) begin
            imem_we <= 1'b0;
         end
         if (accept && drop) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_riscv_inst_encoder.sv
// Randomized self-checking bench for riscv_inst_encoder with a field-level
// reference model; a second DEPTH=2 instance exercises the overflow path.
module tb_riscv_inst_encoder;
   import riscv_defs::*;

   typedef struct packed {
      logic [3:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } req_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic [3:0]  in_op = '0;
   logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [31:0] in_imm = '0;
   logic        sel = 1'b0;
   logic        rnd_ready = 1'b0, rnd_bit = 1'b1, man_ready = 1'b1;
   logic        imem_ready;

   logic        m_in_ready, m_we, m_err, m_done;
   logic [31:0] m_addr, m_wdata;
   logic [10:0] m_count;
   logic        s_in_ready, s_we, s_err, s_done;
   logic [31:0] s_addr, s_wdata;
   logic [1:0]  s_count;

   logic        o_in_ready, o_we, o_err, o_done;
   logic [31:0] o_addr, o_wdata, o_count;

   int unsigned n_vec = 0, n_miss = 0;
   logic [31:0] got_addr[$], got_data[$];
   req_t        req_q[$];
   logic        prev_stall = 1'b0;
   logic [31:0] prev_addr = '0, prev_data = '0;

   always #5 clk = ~clk;

   assign imem_ready = rnd_ready ? rnd_bit : man_ready;
   assign o_in_ready = sel ? s_in_ready : m_in_ready;
   assign o_we       = sel ? s_we : m_we;
   assign o_err      = sel ? s_err : m_err;
   assign o_done     = sel ? s_done : m_done;
   assign o_addr     = sel ? s_addr : m_addr;
   assign o_wdata    = sel ? s_wdata : m_wdata;
   assign o_count    = sel ? 32'(s_count) : 32'(m_count);

   riscv_inst_encoder #(.BASE_ADDR(32'h0), .DEPTH(1024)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start && !sel), .in_valid(in_valid && !sel),
      .in_ready(m_in_ready), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last), .imem_we(m_we),
      .imem_ready(imem_ready), .imem_addr(m_addr), .imem_wdata(m_wdata),
      .count(m_count), .err(m_err), .done(m_done)
   );

   riscv_inst_encoder #(.BASE_ADDR(32'h0), .DEPTH(2)) u_small (
      .clk(clk), .rst_n(rst_n), .start(start && sel), .in_valid(in_valid && sel),
      .in_ready(s_in_ready), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last), .imem_we(s_we),
      .imem_ready(imem_ready), .imem_addr(s_addr), .imem_wdata(s_wdata),
      .count(s_count), .err(s_err), .done(s_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Random memory back-pressure, changed away from the sampling edge.
   always @(posedge clk) begin
      #1;
      rnd_bit = ($urandom_range(0, 3) != 0);
   end

   // Write monitor: records handshakes and checks that stalled writes hold.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_we", {31'd0, o_we}, 32'd1);
            check("hold_addr", o_addr, prev_addr);
            check("hold_data", o_wdata, prev_data);
         end
         if (o_we && !imem_ready) check("stall_in_ready", {31'd0, o_in_ready}, 32'd0);
         if (o_we && imem_ready) begin
            got_addr.push_back(o_addr);
            got_data.push_back(o_wdata);
         end
         prev_stall = o_we && !imem_ready;
         prev_addr  = o_addr;
         prev_data  = o_wdata;
      end
   end

   // ---------------- reference model ----------------
   function automatic bit ref_legal(input req_t r);
      int s;
      s = $signed(r.imm);
      case (r.op)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4: return 1'b1;
         4'd5, 4'd6, 4'd7: return (s >= -2048) && (s <= 2047);
         4'd9: return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
         4'd8: return (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] bits(input logic [31:0] v, input int hi, input int lo);
      return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
   endfunction

   function automatic logic [31:0] ref_word(input req_t r);
      int unsigned f3_tab[5] = '{0, 0, 2, 6, 7};
      logic [31:0] rd, rs1, rs2, u;
      rd  = 32'(r.rd);
      rs1 = 32'(r.rs1);
      rs2 = 32'(r.rs2);
      u   = r.imm;
      case (r.op)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4:
            return ((r.op == 4'd1) ? 32'h40000000 : 32'h0) + (rs2 << 20) + (rs1 << 15)
                   + (f3_tab[r.op] << 12) + (rd << 7) + 32'd51;
         4'd5: return (bits(u, 11, 0) << 20) + (rs1 << 15) + (rd << 7) + 32'd19;
         4'd6: return (bits(u, 11, 0) << 20) + (rs1 << 15) + (32'd2 << 12) + (rd << 7) + 32'd3;
         4'd7: return (bits(u, 11, 5) << 25) + (rs2 << 20) + (rs1 << 15) + (32'd2 << 12)
                      + (bits(u, 4, 0) << 7) + 32'd35;
         4'd9: return (bits(u, 12, 12) << 31) + (bits(u, 10, 5) << 25) + (rs2 << 20)
                      + (rs1 << 15) + (bits(u, 4, 1) << 8) + (bits(u, 11, 11) << 7) + 32'd99;
         4'd8: return (bits(u, 20, 20) << 31) + (bits(u, 10, 1) << 21) + (bits(u, 11, 11) << 20)
                      + (bits(u, 19, 12) << 12) + (rd << 7) + 32'd111;
         default: return 32'd0;
      endcase
   endfunction

   function automatic req_t mk(input logic [3:0] op, input int rd, input int rs1,
                               input int rs2, input int imm);
      req_t r;
      r.op = op; r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.imm = 32'(imm);
      return r;
   endfunction

   function automatic req_t rand_req();
      req_t r;
      int bnd[10] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, -1048576, 1048574, 1048576};
      r.op  = ($urandom_range(0, 15) < 14) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      r.rd  = 5'($urandom);
      r.rs1 = 5'($urandom);
      r.rs2 = 5'($urandom);
      case ($urandom_range(0, 5))
         0: r.imm = $urandom;
         1: r.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
         2: r.imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
         3: r.imm = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
         4: r.imm = 32'(bnd[$urandom_range(0, 9)]);
         default: r.imm = 32'(int'($urandom_range(0, 2097151)) - 1048576);
      endcase
      return r;
   endfunction

   // Runs one load of req_q on the selected instance and compares with the model.
   task automatic run_load(input string tag, input bit strict);
      logic [31:0] exp_addr[$], exp_data[$];
      int unsigned depth, k, waited;
      bit e_err;
      depth = sel ? 2 : 1024;
      k = 0;
      e_err = 1'b0;
      foreach (req_q[i]) begin
         if (ref_legal(req_q[i]) && k < depth) begin
            exp_addr.push_back(32'(4 * k));
            exp_data.push_back(ref_word(req_q[i]));
            k++;
         end else begin
            e_err = 1'b1;
         end
      end
      got_addr.delete();
      got_data.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      foreach (req_q[i]) begin
         in_valid = 1'b1;
         in_op = req_q[i].op; in_rd = req_q[i].rd; in_rs1 = req_q[i].rs1;
         in_rs2 = req_q[i].rs2; in_imm = req_q[i].imm;
         in_last = (i == req_q.size() - 1);
         @(negedge clk);
         if (strict) check({tag, "_no_gap"}, {31'd0, o_in_ready}, 32'd1);
         waited = 0;
         while (!o_in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
         end
         if (waited >= 200) check({tag, "_ready_timeout"}, waited, 32'd0);
         tick();
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      waited = 0;
      @(negedge clk);
      while (!o_done && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_done"}, {31'd0, o_done}, 32'd1);
      check({tag, "_count"}, o_count, k);
      check({tag, "_err"}, {31'd0, o_err}, {31'd0, e_err});
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'd0, o_done}, 32'd0);
      check({tag, "_n_writes"}, got_data.size(), exp_data.size());
      foreach (exp_data[i]) begin
         if (i < got_data.size()) begin
            check({tag, "_addr"}, got_addr[i], exp_addr[i]);
            check({tag, "_data"}, got_data[i], exp_data[i]);
         end
      end
   endtask

   task automatic check_word(input int unsigned i, input logic [31:0] a, input logic [31:0] d);
      if (i < got_data.size()) begin
         check("spec_addr", got_addr[i], a);
         check("spec_data", got_data[i], d);
      end else begin
         check("spec_missing", got_data.size(), i + 1);
      end
   endtask

   initial begin
      #200000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned w;
      #3;
      check("rst_in_ready", {31'd0, o_in_ready}, 32'd0);
      check("rst_we", {31'd0, o_we}, 32'd0);
      check("rst_addr", o_addr, 32'h0);
      check("rst_wdata", o_wdata, 32'h0);
      check("rst_count", o_count, 32'd0);
      check("rst_err", {31'd0, o_err}, 32'd0);
      check("rst_done", {31'd0, o_done}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Requests while idle are not consumed.
      in_valid = 1'b1;
      in_op = ENC_ADD;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("idle_in_ready", {31'd0, o_in_ready}, 32'd0);
         tick();
      end
      in_valid = 1'b0;
      check("idle_no_write", got_data.size(), 32'd0);

      req_q = '{mk(ENC_ADDI, 1, 0, 0, 5)};
      run_load("addi", 1'b1);
      check_word(0, 32'h0, 32'h00500093);

      req_q = '{mk(ENC_ADD, 3, 1, 2, 0), mk(ENC_SUB, 3, 1, 2, 0)};
      run_load("addsub", 1'b1);
      check_word(0, 32'h0, 32'h002081B3);
      check_word(1, 32'h4, 32'h402081B3);

      req_q = '{mk(ENC_LW, 5, 2, 0, 8), mk(ENC_SW, 0, 2, 5, 12),
                mk(ENC_BEQ, 0, 1, 2, -4), mk(ENC_JAL, 1, 0, 0, 8)};
      run_load("mem_br", 1'b1);
      check_word(0, 32'h0, 32'h00812283);
      check_word(1, 32'h4, 32'h00512623);
      check_word(2, 32'h8, 32'hFE208EE3);
      check_word(3, 32'hC, 32'h008000EF);

      // Memory stalls the second write for three cycles.
      req_q = '{mk(ENC_ADDI, 1, 0, 0, 1), mk(ENC_ADDI, 2, 0, 0, 2),
                mk(ENC_ADDI, 3, 0, 0, 3), mk(ENC_OR, 4, 1, 2, 0)};
      fork
         run_load("stall", 1'b0);
         begin
            w = 0;
            while (got_data.size() < 1 && w < 200) begin
               @(negedge clk);
               w++;
            end
            tick();
            man_ready = 1'b0;
            repeat (3) tick();
            man_ready = 1'b1;
         end
      join

      req_q = '{mk(ENC_ADDI, 1, 0, 0, 2048), mk(ENC_BEQ, 0, 1, 2, 3), mk(ENC_AND, 7, 6, 5, 0)};
      run_load("drop", 1'b0);
      check_word(0, 32'h0, 32'h005373B3);

      // Overflow on the DEPTH=2 instance.
      sel = 1'b1;
      tick();
      req_q = '{mk(ENC_ADDI, 1, 0, 0, 1), mk(ENC_ADDI, 2, 0, 0, 2), mk(ENC_ADDI, 3, 0, 0, 3)};
      run_load("ovf", 1'b0);
      for (int n = 0; n < 3; n++) begin
         rnd_ready = 1'b1;
         req_q.delete();
         for (int i = 0; i < 5; i++) req_q.push_back(rand_req());
         run_load("ovf_rand", 1'b0);
      end
      rnd_ready = 1'b0;
      sel = 1'b0;
      tick();

      // Randomized loads under random back-pressure.
      rnd_ready = 1'b1;
      for (int n = 0; n < 12; n++) begin
         req_q.delete();
         for (int i = 0; i < int'($urandom_range(1, 24)); i++) req_q.push_back(rand_req());
         run_load("rand", 1'b0);
      end
      rnd_ready = 1'b0;
      man_ready = 1'b1;

      // Reset in the middle of a load with a write held in the output register.
      man_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      in_op = 4'd15;
      tick();
      in_op = ENC_ADDI;
      in_imm = 32'd7;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_we", {31'd0, o_we}, 32'd1);
      check("pre_rst_err", {31'd0, o_err}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", {31'd0, o_in_ready}, 32'd0);
      check("mid_rst_we", {31'd0, o_we}, 32'd0);
      check("mid_rst_addr", o_addr, 32'h0);
      check("mid_rst_wdata", o_wdata, 32'h0);
      check("mid_rst_count", o_count, 32'd0);
      check("mid_rst_err", {31'd0, o_err}, 32'd0);
      check("mid_rst_done", {31'd0, o_done}, 32'd0);
      man_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();

      req_q = '{mk(ENC_SLT, 9, 8, 7, 0)};
      run_load("after_rst", 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
